memctrl: RTL and testbench
==========================

// Module: memctrl
// PURPOSE
// - Responder side of the LSB memory-request interface. Accepts one load/store at a time (re/we, addr, op, store_val).
// - Serialises each request into byte accesses on the single-port 8-bit RAM bus.
// - Returns the assembled, extended load value with a one-cycle ls_finished pulse.
// - Sits between lsb and the RAM/IO bus; only bus master in this build.
// PARAMETERS
// - ADDR_WIDTH  32            width of mem_a; low ADDR_WIDTH bits of the byte address are driven
// - IO_BASE     32'h0003_0000 byte addresses >= IO_BASE are IO space (see CONFIGURATION)
// PORTS
// clk_in       in   1   system clock, single clock domain
// rst_n_in     in   1   synchronous active-low reset, sampled on posedge clk_in
// rdy_in       in   1   global ready; low freezes all state
// clear        in   1   pipeline flush (mispredict)
// re           in   1   load request (level, from lsb)
// we           in   1   store request (level, from lsb); re&&we is illegal
// ls_op        in   4   LB=0000 LH=0001 LW=0010 LBU=0100 LHU=0101 SB=1000 SH=1001 SW=1010
// addr         in   32  byte address of access
// store_val    in   32  store data; low 1/2/4 bytes used
// ls_finished  out  1   one-cycle pulse: request complete
// read_val     out  32  load result, valid while ls_finished=1
// mem_a        out  ADDR_WIDTH  RAM byte address
// mem_dout     out  8   RAM write data
// mem_wr       out  1   1=write byte this cycle, 0=read
// mem_din      in   8   RAM read data; byte for address driven in cycle k appears in cycle k+1
// io_buffer_full in 1   IO sink back-pressure (used only with MEMCTRL_IO_STALL_EN)
// BEHAVIOUR
// - All outputs registered; reset (rst_n_in=0 at posedge) forces IDLE, ls_finished=0, read_val=0, mem_a=0, mem_dout=0, mem_wr=0, byte counter=0.
// - rdy_in=0: no state/output register changes, except mem_wr is forced 0 (no RAM write while paused); resumes exactly where it left off.
// - States: IDLE, BUSY, DONE.
// - IDLE: if re|we at edge E0, latch addr/op/store_val; n = 1/2/4 from ls_op[1:0].
//   Drive mem_a=addr and mem_wr=we (mem_dout=store_val[7:0] for a store); go BUSY, counter k=1.
// - BUSY, edges E1..E(n-1): drive mem_a=addr+k; writes drive mem_dout=byte k, mem_wr=1; reads drive mem_wr=0.
//   Reads also capture mem_din into byte k-1.
// - Edge En: reads capture the last byte into read_val, extended per ls_op.
//   Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW none.
//   mem_wr=0, ls_finished=1, go DONE. Latency: ls_finished high n cycles after accept edge.
// - DONE: one-cycle turnaround; re/we ignored (lsb may still hold stale re); ls_finished=0 at next edge, go IDLE.
//   Minimum request period n+2 cycles.
// - Address arithmetic: addr+k modulo 2^32; misaligned accesses allowed, bytes fetched sequentially, little-endian.
// - clear (with rdy_in=1):
//   - Load in BUSY: aborted; next edge goes IDLE, no ls_finished, mem_wr=0.
//   - Store in progress: always completes and pulses ls_finished (stores are committed).
//   - clear in IDLE blocks acceptance that cycle; clear and ls_finished coincident: pulse stands.
// - read_val holds last load value between loads; stores leave read_val unchanged.
// - Reset mid-store: mem_wr=0 from the next edge; partial RAM write is accepted.
// CONFIGURATION
// - MEMCTRL_IO_STALL_EN defined: a store with addr >= IO_BASE is not accepted (stays IDLE) while io_buffer_full=1.
//   Once accepted it proceeds normally; loads are unaffected.
// - Not defined: io_buffer_full is ignored; IO stores accepted like RAM stores.
// TESTING
// - RAM[0x1000..3]=11,22,33,44; LW @0x1000 -> mem_a 1000..1003 in consecutive cycles, ls_finished 4 cycles after accept, read_val=0x44332211.
// - RAM[0x80]=0x80; LB -> read_val=0xFFFFFF80; LBU -> 0x00000080; each finishes 1 cycle after accept.
// - SH store_val=0x1234BEEF @0x2003 -> (a=2003,dout=EF,wr=1),(a=2004,dout=BE,wr=1); ls_finished at cycle 2; mem_wr=0 after.
// - LW accepted, clear at cycle 2 -> no ls_finished, mem_wr=0, IDLE next cycle; a new LB accepted afterwards.
// - SW in flight, clear at cycle 1 -> all 4 bytes written, ls_finished still pulses; rdy_in low 3 cycles mid-SW -> mem_wr=0 while low, resumes at same byte.
// - MEMCTRL_IO_STALL_EN: SB @0x30000 with io_buffer_full=1 for 5 cycles -> no mem_wr, no accept; drop full -> write next cycle, ls_finished 1 cycle later.

Source files
------------

// File: rtl/memctrl.sv
// memctrl: serialises one LSB load/store into little-endian byte accesses on an 8-bit RAM bus.
// Build option MEMCTRL_IO_STALL_EN: IO-space stores wait in IDLE while io_buffer_full is high.
module memctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [31:0] IO_BASE    = 32'h0003_0000
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  clear,
    input  logic                  re,
    input  logic                  we,
    input  logic [3:0]            ls_op,
    input  logic [31:0]           addr,
    input  logic [31:0]           store_val,
    output logic                  ls_finished,
    output logic [31:0]           read_val,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [7:0]            mem_dout,
    output logic                  mem_wr,
    input  logic [7:0]            mem_din,
    input  logic                  io_buffer_full
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                r_state, w_state;
    logic [2:0]            r_cnt, w_cnt;
    logic [2:0]            r_len, w_len;
    logic [2:0]            r_op;
    logic                  r_store;
    logic [31:0]           r_addr, r_sval;
    logic [23:0]           r_buf, w_buf;
    logic [31:0]           r_read_val, w_read_val;
    logic [ADDR_WIDTH-1:0] r_mem_a, w_mem_a;
    logic [7:0]            r_mem_dout, w_mem_dout;
    logic                  r_mem_wr, w_mem_wr;
    logic                  r_fin, w_fin;
    logic                  w_accept, w_io_stall;
    logic [31:0]           w_addr_k, w_raw;
    logic [7:0]            w_sbyte;
    logic                  w_unused;

`ifdef MEMCTRL_IO_STALL_EN
    assign w_io_stall = we && (addr >= IO_BASE) && io_buffer_full;
    assign w_unused   = ls_op[3];
`else
    assign w_io_stall = 1'b0;
    assign w_unused   = ls_op[3] ^ io_buffer_full ^ (|IO_BASE);
`endif

    assign w_accept = (r_state == S_IDLE) && (re || we) && !clear && !w_io_stall;
    assign w_addr_k = r_addr + {29'd0, r_cnt};

    always_comb begin
        unique case (ls_op[1:0])
            2'b00:   w_len = 3'd1;
            2'b01:   w_len = 3'd2;
            default: w_len = 3'd4;
        endcase
    end

    always_comb begin
        unique case (r_cnt[1:0])
            2'd1:    w_sbyte = r_sval[15:8];
            2'd2:    w_sbyte = r_sval[23:16];
            2'd3:    w_sbyte = r_sval[31:24];
            default: w_sbyte = r_sval[7:0];
        endcase
    end

    // The last byte is taken straight from mem_din so the result lands on the finishing edge.
    always_comb begin
        unique case (r_len)
            3'd1:    w_raw = {24'd0, mem_din};
            3'd2:    w_raw = {16'd0, mem_din, r_buf[7:0]};
            default: w_raw = {mem_din, r_buf};
        endcase
    end

    // NOTE: every next-state value gets a default first so no path through the case infers a latch.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_buf      = r_buf;
        w_read_val = r_read_val;
        w_mem_a    = r_mem_a;
        w_mem_dout = r_mem_dout;
        w_mem_wr   = 1'b0;
        w_fin      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state  = S_BUSY;
                    w_cnt    = 3'd1;
                    w_mem_a  = addr[ADDR_WIDTH-1:0];
                    w_mem_wr = we;
                    if (we) w_mem_dout = store_val[7:0];
                end
            end
            S_BUSY: begin
                if (clear && !r_store) begin
                    w_state = S_IDLE;
                end else if (r_cnt < r_len) begin
                    w_mem_a = w_addr_k[ADDR_WIDTH-1:0];
                    w_cnt   = r_cnt + 3'd1;
                    if (r_store) begin
                        w_mem_dout = w_sbyte;
                        w_mem_wr   = 1'b1;
                    end else begin
                        unique case (r_cnt)
                            3'd1:    w_buf[7:0]   = mem_din;
                            3'd2:    w_buf[15:8]  = mem_din;
                            3'd3:    w_buf[23:16] = mem_din;
                            default: ;
                        endcase
                    end
                end else begin
                    w_state = S_DONE;
                    w_fin   = 1'b1;
                    if (!r_store) begin
                        unique case (r_op)
                            3'b000:  w_read_val = {{24{w_raw[7]}}, w_raw[7:0]};
                            3'b001:  w_read_val = {{16{w_raw[15]}}, w_raw[15:0]};
                            default: w_read_val = w_raw;
                        endcase
                    end
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; rdy_in low freezes everything but mem_wr.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_op       <= '0;
            r_store    <= 1'b0;
            r_addr     <= '0;
            r_sval     <= '0;
            r_buf      <= '0;
            r_read_val <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
            r_fin      <= 1'b0;
        end else if (!rdy_in) begin
            r_mem_wr <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_buf      <= w_buf;
            r_read_val <= w_read_val;
            r_mem_a    <= w_mem_a;
            r_mem_dout <= w_mem_dout;
            r_mem_wr   <= w_mem_wr;
            r_fin      <= w_fin;
            if (w_accept) begin
                r_addr  <= addr;
                r_sval  <= store_val;
                r_op    <= ls_op[2:0];
                r_store <= we;
                r_len   <= w_len;
            end
        end
    end

    assign ls_finished = r_fin;
    assign read_val    = r_read_val;
    assign mem_a       = r_mem_a;
    assign mem_dout    = r_mem_dout;
    assign mem_wr      = r_mem_wr;

endmodule

// File: tb/tb_memctrl.sv
// tb_memctrl: randomized load/store traffic for memctrl against a transaction-level memory model.
// The bench RAM starts from a fixed byte pattern; the model tracks every committed store.
module tb_memctrl;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, clear, re, we, io_buffer_full;
    logic [3:0]  ls_op;
    logic [31:0] addr, store_val;
    logic        ls_finished;
    logic [31:0] read_val;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout, mem_din;
    logic        mem_wr;

    memctrl #(.ADDR_WIDTH(32), .IO_BASE(32'h0003_0000)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear(clear),
        .re(re), .we(we), .ls_op(ls_op), .addr(addr), .store_val(store_val),
        .ls_finished(ls_finished), .read_val(read_val), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    logic [31:0] last_load = '0;
    logic [7:0]  ref_mem [0:65535];
    logic [7:0]  ram     [0:65535];
    bit          ram_vld [0:65535];
    logic [3:0]  ops [8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

    function automatic logic [7:0] init_byte(input logic [15:0] i);
        return i[7:0] ^ i[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [15:0] i);
        return ram_vld[i] ? ram[i] : init_byte(i);
    endfunction

    // Bench RAM: read data for the registered address is ready by the next edge.
    assign mem_din = ram_rd(mem_a[15:0]);

    always @(posedge clk_in) begin
        if (mem_wr) begin
            ram[mem_a[15:0]]     <= mem_dout;
            ram_vld[mem_a[15:0]] <= 1'b1;
            wr_cnt               <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int op_len(input logic [3:0] op);
        case (op[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a);
        logic [31:0] v, ai;
        v = '0;
        for (int i = 0; i < op_len(op); i++) begin
            ai = a + 32'(i);
            v  = v | (32'(ref_mem[ai[15:0]]) << (8 * i));
        end
        case (op)
            OP_LB:   return 32'($signed(v[7:0]));
            OP_LH:   return 32'($signed(v[15:0]));
            default: return v;
        endcase
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, " ls_finished"}, ls_finished, 0);
        check({tag, " read_val"}, read_val, 0);
        check({tag, " mem_a"}, mem_a, 0);
        check({tag, " mem_dout"}, mem_dout, 0);
        check({tag, " mem_wr"}, mem_wr, 0);
    endtask

    // One request from a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_req(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] sv, input int clr_at, input int pause_at,
                           input int pause_len);
        bit          st, abort, seen;
        int          n, act, wr0;
        logic [31:0] exp_val, ai;
        st      = op[3];
        n       = op_len(op);
        abort   = !st && clr_at >= 1 && clr_at <= n;
        seen    = 1'b0;
        act     = 0;
        wr0     = wr_cnt;
        exp_val = st ? last_load : ref_load(op, a);
        ls_op = op; addr = a; store_val = sv; re = !st; we = st;
        for (int j = 0; j < n + pause_len + 4; j++) begin
            clear  = (j == clr_at);
            rdy_in = !(pause_len > 0 && j >= pause_at && j < pause_at + pause_len);
            if (clear && !st) re = 1'b0;
            @(negedge clk_in);
            if (j > 0 && rdy_in) act++;
            if (seen) begin
                check({tag, " pulse_len"}, ls_finished, 0);
                check({tag, " read_val_hold"}, read_val, exp_val);
                break;
            end
            if (!rdy_in) begin
                check({tag, " paused_wr"}, mem_wr, 0);
            end else if (act < n && !(abort && act >= clr_at)) begin
                ai = a + 32'(act);
                check({tag, " mem_a"}, mem_a, ai);
                check({tag, " mem_wr"}, mem_wr, st);
                if (st) check({tag, " mem_dout"}, mem_dout, sv[8*act +: 8]);
            end
            if (ls_finished) begin
                seen = 1'b1;
                check({tag, " latency"}, act, n);
                check({tag, " read_val"}, read_val, exp_val);
            end
        end
        re = 1'b0; we = 1'b0; clear = 1'b0; rdy_in = 1'b1;
        check({tag, " finished"}, seen, !abort);
        if (st) begin
            for (int i = 0; i < n; i++) begin
                ai = a + 32'(i);
                ref_mem[ai[15:0]] = sv[8*i +: 8];
            end
            for (int i = 0; i < n; i++) begin
                ai = a + 32'(i);
                check({tag, " ram"}, ram_rd(ai[15:0]), ref_mem[ai[15:0]]);
            end
            check({tag, " writes"}, wr_cnt - wr0, n);
        end else begin
            check({tag, " writes"}, wr_cnt - wr0, 0);
            if (!abort) last_load = exp_val;
        end
        check({tag, " read_val_end"}, read_val, last_load);
    endtask

    task automatic idle_clear_test();
        int wr0;
        bit any;
        wr0 = wr_cnt;
        any = 1'b0;
        ls_op = OP_SB; addr = 32'h0000_0500; store_val = 32'h0000_00AA; we = 1'b1; clear = 1'b1;
        @(negedge clk_in);
        we = 1'b0; clear = 1'b0;
        repeat (4) begin
            @(negedge clk_in);
            if (ls_finished) any = 1'b1;
        end
        check("idle_clear finished", any, 0);
        check("idle_clear writes", wr_cnt - wr0, 0);
    endtask

    task automatic reset_mid_store();
        logic [31:0] a, ai, sv;
        a  = 32'h0000_3000;
        sv = 32'hCAFE_F00D;
        ls_op = OP_SW; addr = a; store_val = sv; we = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b0; we = 1'b0;
        @(negedge clk_in);
        check_reset_state("mid_store_reset");
        rst_n_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ai = a + 32'(i);
            ref_mem[ai[15:0]] = sv[8*i +: 8];
        end
        last_load = '0;
        for (int i = 0; i < 4; i++) begin
            ai = a + 32'(i);
            check("mid_store_reset ram", ram_rd(ai[15:0]), ref_mem[ai[15:0]]);
        end
        @(negedge clk_in);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        int          n, clr, pat, plen;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
        rst_n_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; re = 1'b0; we = 1'b0;
        io_buffer_full = 1'b0; ls_op = '0; addr = '0; store_val = '0;
        repeat (3) @(negedge clk_in);
        check_reset_state("reset");
        rst_n_in = 1'b1;
        @(negedge clk_in);

        run_req("pre0", OP_SB, 32'h0000_1000, 32'h11, -1, 0, 0);
        run_req("pre1", OP_SB, 32'h0000_1001, 32'h22, -1, 0, 0);
        run_req("pre2", OP_SB, 32'h0000_1002, 32'h33, -1, 0, 0);
        run_req("pre3", OP_SB, 32'h0000_1003, 32'h44, -1, 0, 0);
        run_req("lw_1000", OP_LW, 32'h0000_1000, 32'h0, -1, 0, 0);
        check("lw_1000 value", read_val, 32'h4433_2211);

        run_req("pre80", OP_SB, 32'h0000_0080, 32'h80, -1, 0, 0);
        run_req("lb_80", OP_LB, 32'h0000_0080, 32'h0, -1, 0, 0);
        check("lb_80 value", read_val, 32'hFFFF_FF80);
        run_req("lbu_80", OP_LBU, 32'h0000_0080, 32'h0, -1, 0, 0);
        check("lbu_80 value", read_val, 32'h0000_0080);

        run_req("sh_2003", OP_SH, 32'h0000_2003, 32'h1234_BEEF, -1, 0, 0);
        check("sh_2003 byte0", ram_rd(16'h2003), 8'hEF);
        check("sh_2003 byte1", ram_rd(16'h2004), 8'hBE);

        run_req("lw_abort", OP_LW, 32'h0000_1000, 32'h0, 2, 0, 0);
        run_req("lb_after_abort", OP_LB, 32'h0000_0080, 32'h0, -1, 0, 0);
        run_req("sw_clear", OP_SW, 32'h0000_1800, 32'hDEAD_BEEF, 1, 0, 0);
        run_req("sw_pause", OP_SW, 32'h0000_1900, 32'h0BAD_CAFE, -1, 2, 3);
        run_req("lw_pause", OP_LW, 32'h0000_1900, 32'h0, -1, 1, 3);
        run_req("lw_wrap", OP_LW, 32'hFFFF_FFFE, 32'h0, -1, 0, 0);
        run_req("lh_wrap", OP_LH, 32'hFFFF_FFFF, 32'h0, -1, 0, 0);
        run_req("lhu_done_clear", OP_LHU, 32'h0000_2003, 32'h0, 3, 0, 0);
        idle_clear_test();
        io_buffer_full = 1'b1;
        run_req("io_sb", OP_SB, 32'h0003_0000, 32'h0000_005A, -1, 0, 0);
        io_buffer_full = 1'b0;
        reset_mid_store();
        run_req("lw_after_reset", OP_LW, 32'h0000_3000, 32'h0, -1, 0, 0);

        for (int t = 0; t < 300; t++) begin
            op   = ops[$urandom_range(0, 7)];
            n    = op_len(op);
            a    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                               : 32'($urandom);
            clr  = -1;
            pat  = 0;
            plen = 0;
            if ($urandom_range(0, 9) == 0) begin
                clr = $urandom_range(1, n + 1);
            end else if ($urandom_range(0, 5) == 0) begin
                pat  = $urandom_range(1, n);
                plen = $urandom_range(1, 3);
            end
            io_buffer_full = 1'($urandom_range(0, 1));
            run_req("rand", op, a, 32'($urandom), clr, pat, plen);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
